// File: rtl/gate_sweep_pkg.sv
// Shared types and sizes for the gate sweep controller.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int VEC_W       = 5;
  localparam int NUM_VECTORS = 32;
  localparam int ERR_W       = 6;

endpackage

// File: rtl/gate_sweep_dwell_cnt.sv
// Dwell counter: counts 0..DWELL_CYCLES-1 while enabled and flags the final cycle.
module gate_sweep_dwell_cnt #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [7:0] cnt;

  assign last = (cnt == 8'(DWELL_CYCLES - 1));

  // Wrap back to zero after the final dwell cycle so the next vector starts cleanly.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all 32 operand/function combinations through an external three-input
// gate, captures its response into a truth table and counts mismatches.
module gate_sweep_ctrl #(
  parameter int DWELL_CYCLES = 4,
  parameter int NUM_VECTORS  = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_expected,
  input  logic        i_f,
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic [1:0]  o_code,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_table,
  output logic [5:0]  o_err_cnt
);

  import gate_sweep_pkg::*;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  state_t             state;
  state_t             next_state;
  logic [VEC_W-1:0]   vec;
  logic [31:0]        tbl;
  logic [ERR_W-1:0]   err_cnt;
  logic               last;
  logic               dwell_clear;
  logic               dwell_enable;

  assign dwell_enable = (state == APPLY);
  assign dwell_clear  = (state != APPLY) || i_abort;

  gate_sweep_dwell_cnt #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk    (i_clk),
    .rst    (i_rst),
    .clear  (dwell_clear),
    .enable (dwell_enable),
    .last   (last)
  );

  assign o_table   = tbl;
  assign o_err_cnt = err_cnt;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and operand outputs; operands are only driven while applying.
  always_comb begin
    next_state = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_a        = 1'b0;
    o_b        = 1'b0;
    o_c        = 1'b0;
    o_code     = 2'b00;
    case (state)
      IDLE: begin
        if (i_start) begin
          next_state = APPLY;
        end
      end
      APPLY: begin
        o_busy = 1'b1;
        o_a    = vec[0];
        o_b    = vec[1];
        o_c    = vec[2];
        o_code = vec[4:3];
        if (i_abort) begin
          next_state = IDLE;
        end else if (last && (vec == LAST_VEC)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        o_done     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Vector index, captured table and mismatch count; abort beats a coinciding final sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vec     <= '0;
      tbl     <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            vec     <= '0;
            tbl     <= '0;
            err_cnt <= '0;
          end
        end
        APPLY: begin
          if (i_abort) begin
            vec     <= '0;
            tbl     <= '0;
            err_cnt <= '0;
          end else if (last) begin
            tbl[vec] <= i_f;
            if (i_f != i_expected[vec]) begin
              err_cnt <= err_cnt + ERR_W'(1);
            end
            if (vec != LAST_VEC) begin
              vec <= vec + VEC_W'(1);
            end
          end
        end
        DONE: begin
          vec <= '0;
        end
        default: begin
          vec <= '0;
        end
      endcase
    end
  end

endmodule
